matvec_stream_driver: RTL and testbench

Host-side AXI-Stream transmitter and result collector for the matrix-vector multiplier interface. It takes a packed matrix and vector, streams them row-major one element per beat on the matrix and vector channels, and collects the M_SIZE-element result stream into a packed register. It sits on the far side of the multiplier's AXIS ports and acts as the bench/SoC-facing driver.

---
 rtl/matvec_stream_driver_pkg.sv | 18 +
 rtl/matvec_stream_driver_counter.sv | 30 +++
 rtl/matvec_stream_driver.sv | 176 +++++++++++++++++
 tb/tb_matvec_stream_driver.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matvec_stream_driver_pkg.sv
// Shared types for the matrix-vector stream driver: FSM state encoding and
// a helper that sizes counters for a given maximum value.
package matvec_stream_driver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_ROW0 = 3'd1,
    ST_SEND_REST = 3'd2,
    ST_COLLECT   = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/matvec_stream_driver_counter.sv
// Parameterised beat counter with synchronous clear, enable and a
// terminal-count flag that is high while the count equals TERMINAL.
module stream_beat_counter #(
  parameter int WIDTH    = 8,
  parameter int TERMINAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  // Count register: clear has priority over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end else begin
      count <= count;
    end
  end

  assign tc = (count == WIDTH'(TERMINAL));

endmodule

// File: rtl/matvec_stream_driver.sv
// Host-side AXI-Stream driver: streams a latched matrix/vector row-major to
// the multiplier and collects the M_SIZE-element result into a packed bus.
module matvec_stream_driver
  import matvec_stream_driver_pkg::*;
#(
  parameter int D_WIDTH        = 32,
  parameter int M_SIZE         = 10,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic                             peer_reset_done,
  input  logic                             start,
  input  logic [D_WIDTH*M_SIZE*M_SIZE-1:0] i_matrix,
  input  logic [D_WIDTH*M_SIZE-1:0]        i_vector,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [D_WIDTH*M_SIZE-1:0]        o_result,
  output logic                             o_result_valid,
  output logic                             m_axis_matrix_valid,
  output logic [D_WIDTH-1:0]               m_axis_matrix,
  input  logic                             m_axis_matrix_ready,
  output logic                             m_axis_vector_valid,
  output logic [D_WIDTH-1:0]               m_axis_vector,
  input  logic                             m_axis_vector_ready,
  input  logic                             s_axis_result_valid,
  input  logic [D_WIDTH-1:0]               s_axis_result,
  output logic                             s_axis_result_ready
);

  localparam int N_BEATS = M_SIZE * M_SIZE;
  localparam int SEND_W  = cnt_width(N_BEATS);
  localparam int RES_W   = cnt_width(M_SIZE);
  localparam int TO_W    = cnt_width(TIMEOUT_CYCLES);
  localparam int TO_TERM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam bit TO_EN   = (TIMEOUT_CYCLES > 0);

  state_e                        state_r, state_s;
  logic [D_WIDTH*N_BEATS-1:0]    matrix_r;
  logic [D_WIDTH*M_SIZE-1:0]     vector_r;
  logic [SEND_W-1:0]             send_idx_s, next_idx_s;
  logic [RES_W-1:0]              res_idx_s;
  logic [TO_W-1:0]               to_cnt_s;
  logic send_tc_s, res_tc_s, to_tc_s, row0_last_s;
  logic start_acc_s, send_fire_s, res_fire_s, timeout_s;

  stream_beat_counter #(.WIDTH(SEND_W), .TERMINAL(N_BEATS - 1)) u_send_cnt (
    .clk(aclk), .rst_n(aresetn), .clr(start_acc_s), .en(send_fire_s),
    .count(send_idx_s), .tc(send_tc_s)
  );

  stream_beat_counter #(.WIDTH(RES_W), .TERMINAL(M_SIZE - 1)) u_res_cnt (
    .clk(aclk), .rst_n(aresetn), .clr(start_acc_s), .en(res_fire_s),
    .count(res_idx_s), .tc(res_tc_s)
  );

  // Idle-cycle counter saturates at TIMEOUT_CYCLES so it never wraps.
  stream_beat_counter #(.WIDTH(TO_W), .TERMINAL(TO_TERM)) u_to_cnt (
    .clk(aclk), .rst_n(aresetn), .clr(start_acc_s | res_fire_s),
    .en((state_r == ST_COLLECT) && !res_fire_s && (to_cnt_s != TO_W'(TIMEOUT_CYCLES))),
    .count(to_cnt_s), .tc(to_tc_s)
  );

  assign row0_last_s = (send_idx_s == SEND_W'(M_SIZE - 1));
  assign next_idx_s  = send_idx_s + SEND_W'(1);

  // Next-state and handshake decode.
  always_comb begin
    state_s     = state_r;
    start_acc_s = 1'b0;
    send_fire_s = 1'b0;
    res_fire_s  = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && peer_reset_done) begin
          start_acc_s = 1'b1;
          state_s     = ST_SEND_ROW0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND_ROW0: begin
        send_fire_s = m_axis_matrix_valid && m_axis_matrix_ready &&
                      m_axis_vector_valid && m_axis_vector_ready;
        if (send_fire_s && send_tc_s) begin
          state_s = ST_COLLECT;
        end else if (send_fire_s && row0_last_s) begin
          state_s = ST_SEND_REST;
        end else begin
          state_s = ST_SEND_ROW0;
        end
      end
      ST_SEND_REST: begin
        send_fire_s = m_axis_matrix_valid && m_axis_matrix_ready;
        if (send_fire_s && send_tc_s) begin
          state_s = ST_COLLECT;
        end else begin
          state_s = ST_SEND_REST;
        end
      end
      ST_COLLECT: begin
        res_fire_s = s_axis_result_valid && s_axis_result_ready;
        timeout_s  = TO_EN && !res_fire_s && to_tc_s;
        if (res_fire_s && res_tc_s) begin
          state_s = ST_DONE;
        end else if (timeout_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_COLLECT;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register and status/handshake outputs, all registered from state_s.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r             <= ST_IDLE;
      busy                <= 1'b0;
      done                <= 1'b0;
      m_axis_matrix_valid <= 1'b0;
      m_axis_vector_valid <= 1'b0;
      s_axis_result_ready <= 1'b0;
    end else begin
      state_r             <= state_s;
      busy                <= (state_s == ST_SEND_ROW0) || (state_s == ST_SEND_REST) ||
                             (state_s == ST_COLLECT);
      done                <= (state_s == ST_DONE);
      m_axis_matrix_valid <= (state_s == ST_SEND_ROW0) || (state_s == ST_SEND_REST);
      m_axis_vector_valid <= (state_s == ST_SEND_ROW0);
      s_axis_result_ready <= (state_s == ST_COLLECT);
    end
  end

  // Datapath: operand latch, beat data (held under backpressure), result capture.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      matrix_r       <= '0;
      vector_r       <= '0;
      m_axis_matrix  <= '0;
      m_axis_vector  <= '0;
      o_result       <= '0;
      o_result_valid <= 1'b0;
      error          <= 1'b0;
    end else if (start_acc_s) begin
      matrix_r       <= i_matrix;
      vector_r       <= i_vector;
      m_axis_matrix  <= i_matrix[0 +: D_WIDTH];
      m_axis_vector  <= i_vector[0 +: D_WIDTH];
      o_result       <= '0;
      o_result_valid <= 1'b0;
      error          <= 1'b0;
    end else begin
      if (send_fire_s && !send_tc_s) begin
        m_axis_matrix <= matrix_r[next_idx_s*D_WIDTH +: D_WIDTH];
      end
      if (send_fire_s && (state_r == ST_SEND_ROW0) && !row0_last_s) begin
        m_axis_vector <= vector_r[next_idx_s*D_WIDTH +: D_WIDTH];
      end
      if (res_fire_s) begin
        o_result[res_idx_s*D_WIDTH +: D_WIDTH] <= s_axis_result;
      end
      if (timeout_s) begin
        error <= 1'b1;
      end
      if ((state_s == ST_DONE) && (state_r == ST_COLLECT)) begin
        o_result_valid <= !timeout_s;
      end
    end
  end

endmodule

// File: tb/tb_matvec_stream_driver.sv
// Bench for matvec_stream_driver (M_SIZE=2, TIMEOUT_CYCLES=8): acts as the
// multiplier peer, scoreboards streamed beats and checks collected results.
module tb_matvec_stream_driver;
  localparam int DW = 32;
  localparam int MS = 2;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, prd, start;
  logic [DW*MS*MS-1:0] i_matrix;
  logic [DW*MS-1:0]    i_vector, o_result;
  logic busy, done, error, orv;
  logic mv, mr, vv, vr, rv, rr;
  logic [DW-1:0] md, vd, rd;

  int checks = 0;
  int failures = 0;
  int send_cycles = 0;
  int done_cnt = 0;
  logic [31:0] mq[$], vq[$], cap_m[$], cap_v[$];
  bit m_hold_pend, v_hold_pend;
  logic [31:0] m_hold_val, v_hold_val;

  typedef struct {
    int          mode;
    logic [31:0] m [4];
    logic [31:0] v [2];
    logic [31:0] r [2];
    int          cyc;
  } vec_t;
  vec_t tbl [5];

  matvec_stream_driver #(.D_WIDTH(DW), .M_SIZE(MS), .TIMEOUT_CYCLES(TO)) dut (
    .aclk(clk), .aresetn(rst_n), .peer_reset_done(prd), .start(start),
    .i_matrix(i_matrix), .i_vector(i_vector),
    .busy(busy), .done(done), .error(error),
    .o_result(o_result), .o_result_valid(orv),
    .m_axis_matrix_valid(mv), .m_axis_matrix(md), .m_axis_matrix_ready(mr),
    .m_axis_vector_valid(vv), .m_axis_vector(vd), .m_axis_vector_ready(vr),
    .s_axis_result_valid(rv), .s_axis_result(rd), .s_axis_result_ready(rr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_row(input int e, input int mode,
                         input logic [31:0] m0, input logic [31:0] m1,
                         input logic [31:0] m2, input logic [31:0] m3,
                         input logic [31:0] v0, input logic [31:0] v1,
                         input logic [31:0] r0, input logic [31:0] r1, input int cyc);
    tbl[e].mode = mode;
    tbl[e].m[0] = m0; tbl[e].m[1] = m1; tbl[e].m[2] = m2; tbl[e].m[3] = m3;
    tbl[e].v[0] = v0; tbl[e].v[1] = v1;
    tbl[e].r[0] = r0; tbl[e].r[1] = r1;
    tbl[e].cyc  = cyc;
  endtask

  // Peer-side monitor: a beat moves on the edge following a negedge where it
  // is seen; row-0 beats need both channels ready.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_hold_pend <= 1'b0;
      v_hold_pend <= 1'b0;
    end else begin
      if (mv) send_cycles <= send_cycles + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (mv) chk("rr_in_send", {63'd0, rr}, 64'd0);
      if (m_hold_pend) chk("m_hold", {31'd0, mv, md}, {32'd1, m_hold_val});
      if (v_hold_pend) chk("v_hold", {31'd0, vv, vd}, {32'd1, v_hold_val});
      m_hold_pend <= mv && !(mr && (!vv || vr));
      m_hold_val  <= md;
      v_hold_pend <= vv && !(vr && mr);
      v_hold_val  <= vd;
      if (mv && mr && (!vv || vr)) begin
        cap_m.push_back(md);
        if (mq.size() == 0) chk("m_extra", {32'd0, md}, 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("m_beat", {32'd0, md}, {32'd0, mq.pop_front()});
      end
      if (vv && vr && mv && mr) begin
        cap_v.push_back(vd);
        if (vq.size() == 0) chk("v_extra", {32'd0, vd}, 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("v_beat", {32'd0, vd}, {32'd0, vq.pop_front()});
      end
    end
  end

  task automatic launch(input int e);
    i_matrix = {tbl[e].m[3], tbl[e].m[2], tbl[e].m[1], tbl[e].m[0]};
    i_vector = {tbl[e].v[1], tbl[e].v[0]};
    for (int i = 0; i < 4; i++) mq.push_back(tbl[e].m[i]);
    for (int i = 0; i < 2; i++) vq.push_back(tbl[e].v[i]);
    cap_m.delete();
    cap_v.delete();
    send_cycles = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("first_beat", {59'd0, busy, mv, vv, error, orv}, 64'b11100);
    chk("first_data", {md, vd}, {tbl[e].m[0], tbl[e].v[0]});
  endtask

  task automatic send_phase(input int mode, input int exp_cyc);
    int guard = 0;
    int stall = 3;
    bit tog = 1'b0;
    while (cap_m.size() < 4 && guard < 100) begin
      mr = 1'b1;
      vr = 1'b1;
      if (mode == 1 && cap_m.size() == 1 && stall > 0) begin
        vr = 1'b0;
        stall--;
      end
      if (mode == 2 && cap_m.size() >= 2) begin
        mr  = tog;
        tog = !tog;
      end
      start = (mode == 3 && guard == 1) ? 1'b1 : 1'b0;
      tick();
      guard++;
    end
    start = 1'b0;
    mr = 1'b1;
    vr = 1'b1;
    chk("mat_count", cap_m.size(), 64'd4);
    chk("vec_count", cap_v.size(), 64'd2);
    chk("collect_entry", {60'd0, mv, vv, rr, busy}, 64'b0011);
    chk("send_cycles", send_cycles, exp_cyc);
  endtask

  // Peer model: multiply the beats actually captured, return n results.
  task automatic send_results(input int n);
    logic [31:0] res [2];
    int g;
    for (int r = 0; r < 2; r++) begin
      res[r] = 32'd0;
      for (int c = 0; c < 2; c++)
        if (cap_m.size() > r*2 + c && cap_v.size() > c)
          res[r] = res[r] + cap_m[r*2 + c] * cap_v[c];
    end
    for (int k = 0; k < n; k++) begin
      rv = 1'b1;
      rd = res[k];
      g = 0;
      while (!rr && g < 50) begin
        tick();
        g++;
      end
      chk("rr_wait", {63'd0, rr}, 64'd1);
      tick();
    end
    rv = 1'b0;
    rd = 32'd0;
  endtask

  task automatic finish_ok(input int e, input int dc0);
    chk("done_pulse", {60'd0, done, busy, orv, error}, 64'b1010);
    chk("o_result", o_result, {tbl[e].r[1], tbl[e].r[0]});
    tick();
    chk("after_done", {60'd0, done, busy, orv, error}, 64'b0010);
    chk("done_count", done_cnt - dc0, 64'd1);
    repeat (3) tick();
    chk("no_restart", {62'd0, mv, busy}, 64'd0);
  endtask

  task automatic run_txn(input int e);
    int dc0 = done_cnt;
    launch(e);
    send_phase(tbl[e].mode, tbl[e].cyc);
    send_results(2);
    finish_ok(e, dc0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    // mode: 0 ready high, 1 vector stall on beat 1, 2 matrix ready toggling, 3 start while busy
    set_row(0, 0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd17, 32'd39, 4);
    set_row(1, 1, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd17, 32'd39, 7);
    set_row(2, 2, 32'd1, 32'd0, 32'd0, 32'd1, 32'd7, 32'd9, 32'd7, 32'd9, 6);
    set_row(3, 3, 32'hFFFF_FFFF, 32'd1, 32'd2, 32'd3, 32'd2, 32'd3, 32'd1, 32'd13, 4);
    set_row(4, 0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4);

    rst_n = 1'b0; prd = 1'b1; start = 1'b0; i_matrix = '0; i_vector = '0;
    mr = 1'b1; vr = 1'b1; rv = 1'b0; rd = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {57'd0, busy, done, error, orv, mv, vv, rr}, 64'd0);
    chk("reset_data", {md, vd}, 64'd0);
    chk("reset_result", o_result, 64'd0);
    rst_n = 1'b1;
    tick();

    for (int e = 0; e < 5; e++) run_txn(e);

    // start ignored while the peer is still in reset
    prd = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("start_no_peer", {61'd0, busy, mv, vv}, 64'd0);
    prd = 1'b1;

    // timeout after a single result beat
    g = done_cnt;
    launch(0);
    send_phase(0, 4);
    send_results(1);
    repeat (7) tick();
    chk("to_early", {61'd0, done, error, busy}, 64'b001);
    tick();
    chk("to_fire", {60'd0, done, error, orv, busy}, 64'b1100);
    chk("to_partial", {32'd0, o_result[31:0]}, 64'd17);
    tick();
    chk("to_hold", {61'd0, done, error, orv}, 64'b010);
    chk("to_done_count", done_cnt - g, 64'd1);

    // asynchronous reset in SEND_REST, then a clean rerun
    launch(0);
    g = 0;
    while (cap_m.size() < 3 && g < 20) begin
      tick();
      g++;
    end
    chk("in_rest", {62'd0, mv, vv}, 64'b10);
    rst_n = 1'b0;
    #1;
    chk("rst_async_ctrl", {57'd0, busy, done, error, orv, mv, vv, rr}, 64'd0);
    chk("rst_async_data", {md, vd}, 64'd0);
    chk("rst_async_result", o_result, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mq.delete();
    vq.delete();
    tick();
    run_txn(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
